bp_be_issue_queue: RTL and testbench

- Parametrised, replayable instruction buffer between the FE queue interface and the BE scheduler.
- Generalises the single-slot FE queue handoff into a depth_p-entry circular buffer with three pointers: write, speculative read and commit.
- Supports roll-back of issued-but-uncommitted entries for replay after a BE stall or exception, and a full flush on redirect.
- Exposes occupancy so the director and detector can throttle fetch without extra state.

---
 rtl/bp_be_issue_queue_if.sv | 32 +++
 rtl/bp_be_issue_queue.sv | 131 +++++++++++++
 tb/tb_bp_be_issue_queue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bp_be_issue_queue_if.sv
// Handshake and status bundle between the FE queue, the issue queue and the BE scheduler.
interface bp_be_issue_queue_if
  #(parameter int entry_width_p = 64
    , parameter int depth_p = 16
    );

  localparam int ptr_width_lp = $clog2(depth_p) + 1;

  logic [entry_width_p-1:0] fe_queue_i;
  logic                     fe_queue_v_i;
  logic                     fe_queue_ready_o;
  logic [entry_width_p-1:0] issue_pkt_o;
  logic                     issue_v_o;
  logic                     issue_yumi_i;
  logic                     commit_v_i;
  logic                     roll_v_i;
  logic                     clr_v_i;
  logic                     empty_o;
  logic                     full_o;
  logic [ptr_width_lp-1:0]  count_o;

  modport master
    (output fe_queue_i, fe_queue_v_i, issue_yumi_i, commit_v_i, roll_v_i, clr_v_i
     , input fe_queue_ready_o, issue_pkt_o, issue_v_o, empty_o, full_o, count_o
     );

  modport slave
    (input fe_queue_i, fe_queue_v_i, issue_yumi_i, commit_v_i, roll_v_i, clr_v_i
     , output fe_queue_ready_o, issue_pkt_o, issue_v_o, empty_o, full_o, count_o
     );

endinterface

// File: rtl/bp_be_issue_queue.sv
// Replayable issue buffer: circular register array with write, speculative read
// and commit pointers, supporting replay (roll) and full flush (clear).
module bp_be_issue_queue
  #(parameter int entry_width_p = 64
    , parameter int depth_p = 16
    , localparam int ptr_width_lp = $clog2(depth_p) + 1
    , localparam int idx_width_lp = $clog2(depth_p)
    )
   (input logic clk_i
    , input logic reset_i
    , bp_be_issue_queue_if.slave io
    );

  logic [ptr_width_lp-1:0]  wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0]  wptr_n_s, rptr_n_s, cptr_n_s;
  logic [ptr_width_lp-1:0]  count_s;
  logic [entry_width_p-1:0] mem_r [depth_p];
  logic                     full_s, empty_s, ready_s, issue_v_s, enq_s, deq_s;

  // Status flags and qualified handshakes; ready depends on registered pointers only
  always_comb begin
    count_s   = wptr_r - cptr_r;
    full_s    = (count_s == ptr_width_lp'(depth_p));
    empty_s   = (rptr_r == wptr_r);
    ready_s   = ~full_s;
    issue_v_s = ~empty_s & ~io.roll_v_i & ~io.clr_v_i;
    enq_s     = io.fe_queue_v_i & ready_s & ~io.clr_v_i;
    deq_s     = io.issue_yumi_i & issue_v_s;
  end

  // Pointer next-state: clear beats roll beats issue/commit
  always_comb begin
    wptr_n_s = wptr_r;
    rptr_n_s = rptr_r;
    cptr_n_s = cptr_r;
    if (enq_s) begin
      wptr_n_s = wptr_r + ptr_width_lp'(1);
    end else begin
      wptr_n_s = wptr_r;
    end
    if (io.clr_v_i) begin
      rptr_n_s = wptr_r;
      cptr_n_s = wptr_r;
    end else begin
      if (io.commit_v_i) begin
        cptr_n_s = cptr_r + ptr_width_lp'(1);
      end else begin
        cptr_n_s = cptr_r;
      end
      // Replay restarts from the post-commit pointer
      if (io.roll_v_i) begin
        rptr_n_s = cptr_n_s;
      end else if (deq_s) begin
        rptr_n_s = rptr_r + ptr_width_lp'(1);
      end else begin
        rptr_n_s = rptr_r;
      end
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_n_s;
      rptr_r <= rptr_n_s;
      cptr_r <= cptr_n_s;
    end
  end

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r[idx_width_lp-1:0]] <= io.fe_queue_i;
    end
  end

  assign io.fe_queue_ready_o = ready_s;
  assign io.issue_pkt_o      = mem_r[rptr_r[idx_width_lp-1:0]];
  assign io.issue_v_o        = issue_v_s;
  assign io.empty_o          = empty_s;
  assign io.full_o           = full_s;
  assign io.count_o          = count_s;

  bp_be_issue_queue_chk
    #(.depth_p(depth_p), .ptr_width_lp(ptr_width_lp))
    chk
     (.clk_i(clk_i)
      , .reset_i(reset_i)
      , .issue_yumi_i(io.issue_yumi_i)
      , .issue_v_o(issue_v_s)
      , .commit_v_i(io.commit_v_i)
      , .clr_v_i(io.clr_v_i)
      , .cptr(cptr_r)
      , .rptr(rptr_r)
      );

endmodule

// Protocol and parameter checks for the issue queue.
module bp_be_issue_queue_chk
  #(parameter int depth_p = 16
    , parameter int ptr_width_lp = 5
    )
   (input logic clk_i
    , input logic reset_i
    , input logic issue_yumi_i
    , input logic issue_v_o
    , input logic commit_v_i
    , input logic clr_v_i
    , input logic [ptr_width_lp-1:0] cptr
    , input logic [ptr_width_lp-1:0] rptr
    );

  localparam bit depth_ok_lp = (depth_p >= 2) && ((depth_p & (depth_p - 1)) == 0);

  // Depth must be a power of two so pointer low bits index the array directly
  always_ff @(posedge clk_i) begin
    assert (depth_ok_lp) else $error("depth_p must be a power of two >= 2");
  end

  assert property (@(posedge clk_i) disable iff (reset_i) issue_yumi_i |-> issue_v_o)
    else $error("issue_yumi_i asserted without issue_v_o");

  assert property (@(posedge clk_i) disable iff (reset_i) (commit_v_i & ~clr_v_i) |-> (cptr != rptr))
    else $error("commit_v_i with no issued entry");

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Randomized and directed bench for bp_be_issue_queue against a queue-based reference model.
module tb_bp_be_issue_queue;

  localparam int W  = 64;
  localparam int D  = 16;
  localparam int PW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_be_issue_queue_if #(.entry_width_p(W), .depth_p(D)) q ();

  bp_be_issue_queue #(.entry_width_p(W), .depth_p(D)) dut
    (.clk_i(clk)
     , .reset_i(reset)
     , .io(q)
     );

  // Reference model: all live (uncommitted) entries oldest first, and how many are issued
  logic [W-1:0] live[$];
  int issued;
  int n_cmp;
  int n_err;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    q.fe_queue_i   = '0;
    q.fe_queue_v_i = 1'b0;
    q.issue_yumi_i = 1'b0;
    q.commit_v_i   = 1'b0;
    q.roll_v_i     = 1'b0;
    q.clr_v_i      = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    repeat (cycles) @(posedge clk);
    live.delete();
    issued = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: requested yumi/commit are only applied when legal for the model
  task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit c,
                      input bit r, input bit x);
    bit exp_v, yy, cc, acc;
    @(negedge clk);
    exp_v = (issued < live.size()) && !r && !x;
    yy    = y && exp_v;
    cc    = c && (issued > 0);
    acc   = v && (live.size() < D) && !x;
    q.fe_queue_i   = d;
    q.fe_queue_v_i = v;
    q.issue_yumi_i = yy;
    q.commit_v_i   = cc;
    q.roll_v_i     = r;
    q.clr_v_i      = x;
    #1;
    check_val("ready", 64'(q.fe_queue_ready_o), 64'(live.size() < D));
    check_val("empty", 64'(q.empty_o), 64'(issued == live.size()));
    check_val("full",  64'(q.full_o), 64'(live.size() == D));
    check_val("count", 64'(q.count_o), 64'(live.size()));
    check_val("issue_v", 64'(q.issue_v_o), 64'(exp_v));
    if (exp_v) check_val("issue_pkt", q.issue_pkt_o, live[issued]);
    @(posedge clk);
    if (x) begin
      live.delete();
      issued = 0;
    end else begin
      if (cc) begin
        void'(live.pop_front());
        issued--;
      end
      if (r) issued = 0;
      else if (yy) issued++;
      if (acc) live.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    issued = 0;
    reset = 1'b1;
    drive_idle();
    do_reset(2);
    idle(1);

    // In-order enqueue and issue of A0..A3, then commit all
    for (int i = 0; i < 4; i++) step(1'b1, 64'hA0 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill to full, reject a 17th, free a slot with one commit
    for (int i = 0; i < D; i++) step(1'b1, 64'hF0 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Issue B0..B2, commit one, roll back: replay starts at B1
    for (int i = 0; i < 3; i++) step(1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Issue 5, then clear together with an enqueue of 0xCC that must be dropped
    for (int i = 0; i < 6; i++) step(1'b1, 64'hC0 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Stream 40 entries with commit trailing issue by one cycle (pointers wrap twice)
    for (int i = 0; i < 44; i++) step(i < 40, 64'h100 + 64'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Simultaneous commit and roll with 3 issued entries: next issue is the 2nd entry
    for (int i = 0; i < 4; i++) step(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Randomized traffic with occasional replay, flush and mid-operation reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
      end else begin
        step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
